fetch_stage: RTL

- Instruction-fetch stage: PC register, instruction-memory request handshake, and IF/ID pipeline register.
- Directly upstream of the decode-stage hazard checker. Its IF/ID output is the instruction that the hazard checker inspects for source registers.
- Consumes the hazard checker's pcenable/idifenable stall outputs and the EX-stage branch/jump redirect.
- Inserts NOP bubbles on memory latency and on flush.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage port bundle: hazard-checker stall inputs, EX redirect, the
// instruction-memory handshake and the IF/ID register outputs.
interface fetch_stage_if;
  logic        pcenable;
  logic        idifenable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instructionFetch;
  logic [31:0] pc_id;
  logic        fetch_valid;

  modport master (
    input  pcenable, idifenable, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, instructionFetch, pc_id, fetch_valid
  );

  modport slave (
    output pcenable, idifenable, redirect, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instructionFetch, pc_id, fetch_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request handshake, IF/ID register with bubbles.
// Optional stall/flush counters enabled by `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hFC00_0000
) (
  input  logic          clk,
  input  logic          rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt,
`endif
  fetch_stage_if.master f
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc, addr_q, instr_q, pc_id_q, buf_q;
  logic        req_q, vld_q;

  logic        advance, ack;
  logic [31:0] pc_inc, rpc;
  logic        unused_rpc_lsb;

  assign advance        = f.pcenable & f.idifenable;
  // ack without an outstanding request is not a response
  assign ack            = f.imem_ack & req_q;
  assign pc_inc         = pc + 32'd4;
  assign rpc            = {f.redirect_pc[31:2], 2'b00};
  assign unused_rpc_lsb = ^f.redirect_pc[1:0];

  assign f.imem_req         = req_q;
  assign f.imem_addr        = addr_q;
  assign f.instructionFetch = instr_q;
  assign f.pc_id            = pc_id_q;
  assign f.fetch_valid      = vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_id_q <= 32'd0;
      vld_q   <= 1'b0;
      buf_q   <= 32'd0;
    end else if (f.redirect) begin
      pc      <= rpc;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
      buf_q   <= 32'd0;
      req_q   <= 1'b1;
      // an outstanding request must still be retired; its data is dropped
      if ((state == REQ || state == DROP) && !ack) begin
        state <= DROP;
      end else begin
        state  <= REQ;
        addr_q <= rpc;
      end
    end else begin
      case (state)
        IDLE: begin
          state  <= REQ;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        REQ: begin
          if (ack && advance) begin
            instr_q <= f.imem_rdata;
            pc_id_q <= pc_inc;
            vld_q   <= 1'b1;
            pc      <= pc_inc;
            addr_q  <= pc_inc;
          end else if (ack) begin
            buf_q <= f.imem_rdata;
            req_q <= 1'b0;
            state <= HOLD;
          end else if (advance) begin
            instr_q <= NOP_INSTR;
            vld_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            instr_q <= buf_q;
            pc_id_q <= pc_inc;
            vld_q   <= 1'b1;
            pc      <= pc_inc;
            addr_q  <= pc_inc;
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        DROP: begin
          if (advance) begin
            instr_q <= NOP_INSTR;
            vld_q   <= 1'b0;
          end
          if (ack) begin
            state  <= REQ;
            addr_q <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (f.redirect) flush_cnt <= flush_cnt + 32'd1;
      else if (!advance) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule
